// File: rtl/fpga_mem_pkg.sv
// rtl/fpga_mem_pkg.sv - shared types and constants for the cache-line bus responder
//
// Purpose: beat/line geometry, FSM state encoding and the line type used by
//          fpga_mem_responder and fpga_mem_line_ram.
// Ports:   none (package).

package fpga_mem_pkg;

    localparam int BEAT_W     = 32;
    localparam int LINE_BEATS = 8;
    localparam int LINE_W     = 256;
    localparam int OFFSET_W   = 5;

    typedef enum logic [2:0] {
        IDLE,
        RD_LAT_WAIT,
        RD_BEAT,
        WR_BEAT,
        WR_DONE,
        WAIT_REL
    } state_t;

    typedef logic [LINE_W-1:0] line_t;

endpackage

// File: rtl/fpga_mem_line_ram.sv
// rtl/fpga_mem_line_ram.sv - 2**IDX_W x 256-bit line RAM, registered read port
//
// Purpose: backing store for the responder. Full-line writes, reads return
//          data one cycle after re_i is sampled. Contents are not reset.
// Ports:
//   clk      in   clock
//   we_i     in   write enable (full line)
//   waddr_i  in   write line index
//   wdata_i  in   write line data
//   re_i     in   read enable; rdata_o updates on the following edge
//   raddr_i  in   read line index
//   rdata_o  out  registered read line

module fpga_mem_line_ram
    import fpga_mem_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  line_t            wdata_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] raddr_i,
    output line_t            rdata_o
);

    line_t mem_q [2**IDX_W];
    line_t rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fpga_mem_responder.sv
// rtl/fpga_mem_responder.sv - memory-side endpoint of the multiplexed cache-line bus
//
// Purpose: accepts an address phase then 8 x 32-bit beats per line, backed by
//          an internal line RAM. Every handshake produces a one-cycle resp
//          pulse; inputs are ignored for two cycles after each pulse.
// Optional feature: define FPGA_MEM_WAIT_EN to insert pseudo-random wait
//          states (8-bit LFSR, seed 8'hA5) ahead of handshakes.
// Ports:
//   clk                      in   clock, rising edge
//   rst_n                    in   asynchronous active-low reset
//   address_data_bus_c_to_m  in   address (address phase) / write data
//   address_on_c_to_m        in   address phase valid
//   data_on_c_to_m           in   data phase valid
//   read_en_c_to_m           in   read transaction
//   write_en_c_to_m          in   write transaction
//   address_data_bus_m_to_c  out  read beat data, non-zero only with a read resp
//   resp_m_to_c              out  one-cycle accept/response pulse
//   busy                     out  transaction in progress
//   proto_err                out  sticky: both enables seen together

module fpga_mem_responder
    import fpga_mem_pkg::*;
#(
    parameter int IDX_W  = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BEAT_W-1:0] address_data_bus_c_to_m,
    input  logic              address_on_c_to_m,
    input  logic              data_on_c_to_m,
    input  logic              read_en_c_to_m,
    input  logic              write_en_c_to_m,
    output logic [BEAT_W-1:0] address_data_bus_m_to_c,
    output logic              resp_m_to_c,
    output logic              busy,
    output logic              proto_err
);

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [7:0]         lat_q, lat_d;
    logic [1:0]         blank_q, blank_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    line_t              wbuf_q, wbuf_d;
    logic               resp_q, resp_d;
    logic [BEAT_W-1:0]  rdata_q, rdata_d;
    logic               perr_q, perr_d;

    logic               sample;
    logic               rw_none;
    logic               hs_req;
    logic               stall;
    logic               fire;
    logic               ram_we;
    logic               ram_re;
    line_t              ram_rdata;

    // Inputs are only looked at once the post-resp blanking window is over.
    assign sample  = (blank_q == 2'd0);
    assign rw_none = !read_en_c_to_m && !write_en_c_to_m;

`ifdef FPGA_MEM_WAIT_EN
    logic [7:0] lfsr_q;

    // x^8 + x^6 + x^5 + x^4 + 1, free running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // A handshake the current state would accept this cycle.
    always_comb begin
        hs_req = 1'b0;
        case (state_q)
            IDLE:    hs_req = address_on_c_to_m && (read_en_c_to_m != write_en_c_to_m);
            RD_BEAT: hs_req = data_on_c_to_m && read_en_c_to_m;
            WR_BEAT,
            WR_DONE: hs_req = data_on_c_to_m && write_en_c_to_m;
            default: hs_req = 1'b0;
        endcase
    end

    assign fire = sample && hs_req && !stall;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            blank_q <= '0;
            idx_q   <= '0;
            wbuf_q  <= '0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            blank_q <= blank_d;
            idx_q   <= idx_d;
            wbuf_q  <= wbuf_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        idx_d   = idx_q;
        wbuf_d  = wbuf_q;
        perr_d  = perr_q || (sample && read_en_c_to_m && write_en_c_to_m);
        blank_d = fire ? 2'd2 : ((blank_q != 2'd0) ? blank_q - 2'd1 : 2'd0);

        if (state_q != IDLE && sample && rw_none) begin
            // Abort (or normal release from WAIT_REL): drop everything.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fire) begin
                        idx_d   = address_data_bus_c_to_m[OFFSET_W +: IDX_W];
                        cnt_d   = '0;
                        lat_d   = 8'(RD_LAT - 1);
                        state_d = read_en_c_to_m ? RD_LAT_WAIT : WR_BEAT;
                    end
                end
                RD_LAT_WAIT: begin
                    // Counts through the blanking window as well.
                    if (lat_q == 8'd0) begin
                        state_d = RD_BEAT;
                    end else begin
                        lat_d = lat_q - 8'd1;
                    end
                end
                RD_BEAT: begin
                    if (fire) begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_d = WAIT_REL;
                        end
                    end
                end
                WR_BEAT: begin
                    if (fire) begin
                        wbuf_d[{cnt_q, 5'd0} +: BEAT_W] = address_data_bus_c_to_m;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_d = WR_DONE;
                        end
                    end
                end
                WR_DONE: begin
                    if (fire) begin
                        state_d = WAIT_REL;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs and RAM control
    always_comb begin
        resp_d  = fire;
        rdata_d = '0;
        if (fire && state_q == RD_BEAT) begin
            rdata_d = ram_rdata[{cnt_q, 5'd0} +: BEAT_W];
        end
        ram_we = fire && (state_q == WR_DONE);
        // The last RD_LAT_WAIT cycle leaves the line in the RAM read register.
        ram_re = (state_q == RD_LAT_WAIT);
    end

    fpga_mem_line_ram #(
        .IDX_W(IDX_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (idx_q),
        .wdata_i (wbuf_q),
        .re_i    (ram_re),
        .raddr_i (idx_q),
        .rdata_o (ram_rdata)
    );

    assign address_data_bus_m_to_c = rdata_q;
    assign resp_m_to_c             = resp_q;
    assign busy                    = (state_q != IDLE);
    assign proto_err               = perr_q;

endmodule
